// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with RUN/HALTED FSM, exceptions and retired counter
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int               CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic [WIDTH-1:0]     branch_off,
  input  logic                 jump_en,
  input  logic [25:0]          jump_idx,
  input  logic                 jr_en,
  input  logic [WIDTH-1:0]     jr_addr,
  input  logic                 exc_req,
  input  logic                 eret,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [WIDTH-1:0]     pc_out,
  output logic [WIDTH-1:0]     pc_plus4,
  output logic [WIDTH-1:0]     epc,
  output logic [1:0]           exc_cause,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     epc_q, epc_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic                 exc_take;
  logic [1:0]           exc_code;
  logic [WIDTH-1:0]     jump_tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      cause_q   <= 2'b00;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    pc_plus4           = pc_q + WIDTH'(4);
    jump_tgt           = pc_plus4;
    jump_tgt[27:0]     = {jump_idx, 2'b00};

    // A misaligned jr only faults when it would actually have been taken.
    exc_take = 1'b0;
    exc_code = 2'b00;
    if (exc_req) begin
      exc_take = 1'b1;
      exc_code = 2'b01;
    end else if (state_q == RUN && jr_en && jr_addr[1:0] != 2'b00 &&
                 !halt_req && !stall && !eret) begin
      exc_take = 1'b1;
      exc_code = 2'b10;
    end

    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    retired_d = retired_q;

    if (exc_take) begin
      epc_d   = pc_q;
      cause_d = exc_code;
      pc_d    = EXC_VECTOR;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (halt_req) begin
            state_d = HALTED;
          end else if (!stall) begin
            retired_d = retired_q + CNT_WIDTH'(1);
            if (eret) begin
              pc_d    = epc_q;
              cause_d = 2'b00;
            end else if (jr_en) begin
              pc_d = jr_addr;
            end else if (jump_en) begin
              pc_d = jump_tgt;
            end else if (branch_en) begin
              pc_d = pc_plus4 + (branch_off << 2);
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
        HALTED: begin
          if (resume) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_out    = pc_q;
  assign epc       = epc_q;
  assign exc_cause = cause_q;
  assign halted    = (state_q == HALTED);
  assign retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [7:0] S  = 8'h01;
  localparam logic [7:0] B  = 8'h02;
  localparam logic [7:0] J  = 8'h04;
  localparam logic [7:0] JR = 8'h08;
  localparam logic [7:0] X  = 8'h10;
  localparam logic [7:0] E  = 8'h20;
  localparam logic [7:0] H  = 8'h40;
  localparam logic [7:0] R  = 8'h80;

  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] arg;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        halted;
    int          ret;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        halted;
    int          ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_en, jump_en, jr_en, exc_req, eret, halt_req, resume;
  logic [31:0] branch_off, jr_addr;
  logic [25:0] jump_idx;
  logic [31:0] pc_out, pc_plus4, epc;
  logic [1:0]  exc_cause;
  logic        halted;
  logic [3:0]  retired;

  int   tests  = 0;
  int   failed = 0;
  vec_t vecs[$];
  exp_t sb[$];

  pc_sequencer #(.WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_en(branch_en), .branch_off(branch_off),
    .jump_en(jump_en), .jump_idx(jump_idx),
    .jr_en(jr_en), .jr_addr(jr_addr),
    .exc_req(exc_req), .eret(eret), .halt_req(halt_req), .resume(resume),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .epc(epc),
    .exc_cause(exc_cause), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk({tag, " pc_out"},    pc_out,            e.pc);
    chk({tag, " pc_plus4"},  pc_plus4,          e.pc + 32'd4);
    chk({tag, " epc"},       epc,               e.epc);
    chk({tag, " exc_cause"}, {30'b0, exc_cause}, {30'b0, e.cause});
    chk({tag, " halted"},    {31'b0, halted},   {31'b0, e.halted});
    chk({tag, " retired"},   {28'b0, retired},  32'(e.ret % 16));
  endtask

  task automatic drive(input logic [7:0] ctl, input logic [31:0] arg);
    stall      = ctl[0];
    branch_en  = ctl[1];
    jump_en    = ctl[2];
    jr_en      = ctl[3];
    exc_req    = ctl[4];
    eret       = ctl[5];
    halt_req   = ctl[6];
    resume     = ctl[7];
    branch_off = arg;
    jump_idx   = arg[25:0];
    jr_addr    = arg;
  endtask

  task automatic add(input logic [7:0] ctl, input logic [31:0] arg, input logic [31:0] pc,
                     input logic [31:0] e_pc, input logic [1:0] cause, input logic h, input int ret);
    vec_t v;
    v.ctl = ctl; v.arg = arg; v.pc = pc; v.epc = e_pc; v.cause = cause; v.halted = h; v.ret = ret;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    add(0,      32'h0,        32'h4,        32'h0,   2'd0, 1'b0, 1);
    add(0,      32'h0,        32'h8,        32'h0,   2'd0, 1'b0, 2);
    add(0,      32'h0,        32'hC,        32'h0,   2'd0, 1'b0, 3);
    add(0,      32'h0,        32'h10,       32'h0,   2'd0, 1'b0, 4);
    add(0,      32'h0,        32'h14,       32'h0,   2'd0, 1'b0, 5);
    add(JR,     32'h100,      32'h100,      32'h0,   2'd0, 1'b0, 6);
    add(B,      32'hFFFFFFFE, 32'hFC,       32'h0,   2'd0, 1'b0, 7);
    add(J,      32'h40,       32'h100,      32'h0,   2'd0, 1'b0, 8);
    add(JR,     32'h200,      32'h200,      32'h0,   2'd0, 1'b0, 9);
    add(JR,     32'h301,      32'h80,       32'h200, 2'd2, 1'b0, 9);
    add(E,      32'h0,        32'h200,      32'h200, 2'd0, 1'b0, 10);
    add(JR,     32'h40,       32'h40,       32'h200, 2'd0, 1'b0, 11);
    add(X|S|J,  32'h0,        32'h80,       32'h40,  2'd1, 1'b0, 11);
    add(S,      32'h0,        32'h80,       32'h40,  2'd1, 1'b0, 11);
    add(S|B,    32'h10,       32'h80,       32'h40,  2'd1, 1'b0, 11);
    add(JR,     32'h10,       32'h10,       32'h40,  2'd1, 1'b0, 12);
    add(H|B,    32'h4,        32'h10,       32'h40,  2'd1, 1'b1, 12);
    add(B,      32'h4,        32'h10,       32'h40,  2'd1, 1'b1, 12);
    add(B|J,    32'h4,        32'h10,       32'h40,  2'd1, 1'b1, 12);
    add(B|JR,   32'h301,      32'h10,       32'h40,  2'd1, 1'b1, 12);
    add(R,      32'h0,        32'h10,       32'h40,  2'd1, 1'b0, 12);
    add(0,      32'h0,        32'h14,       32'h40,  2'd1, 1'b0, 13);
    add(R,      32'h0,        32'h18,       32'h40,  2'd1, 1'b0, 14);
    add(H|S,    32'h0,        32'h18,       32'h40,  2'd1, 1'b1, 14);
    add(E,      32'h0,        32'h18,       32'h40,  2'd1, 1'b1, 14);
    add(X,      32'h0,        32'h80,       32'h18,  2'd1, 1'b0, 14);
    add(H|X,    32'h0,        32'h80,       32'h80,  2'd1, 1'b0, 14);
    add(E,      32'h0,        32'h80,       32'h80,  2'd0, 1'b0, 15);
    add(JR,     32'hFFFFFFFC, 32'hFFFFFFFC, 32'h80,  2'd0, 1'b0, 16);
    add(0,      32'h0,        32'h0,        32'h80,  2'd0, 1'b0, 17);
    add(B,      32'h3FFFFFFF, 32'h0,        32'h80,  2'd0, 1'b0, 18);
    add(JR|E,   32'h301,      32'h80,       32'h80,  2'd0, 1'b0, 19);

    drive(0, 0);
    reset = 1'b1;
    #2;
    e = '{pc: 32'h0, epc: 32'h0, cause: 2'd0, halted: 1'b0, ret: 0};
    compare("reset", e);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ctl, vecs[i].arg);
      sb.push_back('{pc: vecs[i].pc, epc: vecs[i].epc, cause: vecs[i].cause,
                     halted: vecs[i].halted, ret: vecs[i].ret});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        tests++; failed++;
        $display("FAIL scoreboard: empty queue at vector %0d", i);
      end else begin
        compare($sformatf("vec%0d", i), sb.pop_front());
      end
      @(negedge clk);
    end

    // Enter HALTED, then hit reset asynchronously between edges.
    drive(H, 0);
    @(posedge clk);
    #1;
    chk("halt before reset", {31'b0, halted}, 32'd1);
    drive(X, 0);
    #2;
    reset = 1'b1;
    #1;
    e = '{pc: 32'h0, epc: 32'h0, cause: 2'd0, halted: 1'b0, ret: 0};
    compare("async reset", e);
    @(posedge clk);
    #1;
    compare("reset over exc_req", e);
    @(negedge clk);
    drive(0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    e = '{pc: 32'h4, epc: 32'h0, cause: 2'd0, halted: 1'b0, ret: 1};
    compare("first edge after reset", e);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
